uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//   Memory-mapped UART transmitter in bus region 0x2 (addr[31:28]==4'h2) of the
//   system interconnect, alongside ROM (0x0) and RAM (0x1).
//   The CPU writes bytes into a TX FIFO. A serial FSM shifts each byte out on txd as 8N1.
//   The bus is single-cycle: reads are combinational from registered state, writes take
//   effect at the next clk edge.
// PARAMETERS
//   FIFO_DEPTH    8       TX FIFO entries; power of two, 2..64
//   BAUD_DIV_RST  16'd434 bauddiv reset value in clk cycles per bit (50 MHz / 115200)
// PORTS
//   clk           in   1   system clock
//   rstn          in   1   reset, synchronous, active-low
//   writeEnable   in   1   bus write strobe, sampled at posedge clk
//   addr          in   32  byte address; top nibble already zeroed; addr[3:2] decoded
//   writeData     in   32  bus write data
//   readData      out  32  combinational read data for addr
//   txd           out  1   serial output, idle high
//   irq_tx_empty  out  1   level: FIFO empty and FSM in IDLE
// BEHAVIOUR
//   Register map, by addr[3:2]:
//     00 TXDATA: W pushes writeData[7:0]; R returns 0.
//     01 STATUS, R: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow (sticky),
//        [11:4] count; other bits 0.
//     01 STATUS, W: writing 1 to bit 3 clears overflow; other bits ignored.
//     10 BAUDDIV: R/W [15:0]; upper bits read 0.
//     11 reserved: R 0, W ignored.
//   Reset (rstn==0 at posedge clk): FIFO emptied, FSM=IDLE, txd=1, overflow=0,
//     bauddiv=BAUD_DIV_RST, bit counters 0. readData and irq_tx_empty follow that state.
//   Reset mid-frame aborts the frame: txd=1 on the same edge; the partial byte is lost.
//   Push: the write is accepted iff FIFO is not full in that cycle.
//   Push when full: the byte is dropped and overflow is set, even if a pop occurs that cycle.
//   FSM states:
//     IDLE:  txd=1. If FIFO is not empty, pop the head into the shift reg and go to START.
//     START: txd=0 for one bit period, then go to DATA.
//     DATA:  txd=shift[0], LSB first; shift right each bit period; after 8 bits go to STOP.
//     STOP:  txd=1 for one bit period, then go to IDLE.
//   Bit period: max(bauddiv,1) clk cycles, counted by a down-counter.
//   A new bauddiv value is loaded at the next bit boundary; the current bit is not stretched.
//   Back-to-back: STOP->IDLE->START costs one IDLE cycle, so frames are 10 bit periods + 1 clk.
//   Pop and push in the same cycle: both occur; count is unchanged.
//   Latency: the TXDATA write edge makes FIFO non-empty. The next edge pops and enters
//     START, so txd falls 2 clk after the write edge.
//   txd is registered (glitch-free). count width is $clog2(FIFO_DEPTH)+1.
// STRUCTURE
//   Shared package uart_pkg: register offsets (TXDATA/STATUS/BAUDDIV), STATUS bit
//     indices, FSM state encoding, BAUD_DIV_RST default.
//   Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH), with push/pop/full/empty/count;
//     reusable for a later RX path. The FSM, baud counter and register decode stay top-level.
// TESTING
//   1. Reset: hold rstn=0 for 2 clk -> txd=1, STATUS=0x004, BAUDDIV=434, irq_tx_empty=1.
//   2. Single byte: BAUDDIV=4, write 0xA5 to TXDATA -> txd=0 for 4 clk, then bits
//      1,0,1,0,0,1,0,1 for 4 clk each, then 1 for 4 clk; busy falls; irq_tx_empty=1.
//   3. Full/overflow: BAUDDIV=100, write 9 bytes back-to-back ->
//      - first byte pops at once; bytes 2..9 fill the FIFO; count=8, full=1;
//      - a 10th write is dropped, overflow=1;
//      - write STATUS=0x8 -> overflow=0.
//   4. Back-to-back frames: BAUDDIV=2, write 0x00 and 0xFF ->
//      - second start bit begins exactly 1 clk after the first stop bit ends;
//      - total 41 clk from first txd fall to final idle.
//   5. Mid-frame BAUDDIV change: 8 -> 3 during DATA bit 2 ->
//      - bit 2 lasts 8 clk;
//      - bit 3 onward lasts 3 clk each.
//   6. Reset mid-frame: assert rstn=0 during DATA with 3 bytes queued ->
//      - txd=1 and STATUS=0x004 after the edge;
//      - no further frames after rstn=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets, STATUS bit
// positions, transmitter state encoding and the baud divider default.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam logic [15:0] BAUD_DIV_RST = 16'd434;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Reload value for the bit down-counter; a divider of 0 behaves like 1.
  function automatic logic [15:0] bit_period_m1(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : (div - 16'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes while full and pops
// while empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    else         rd_ptr_d = rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, serial FSM
// with a reloadable bit-period down-counter, registered txd.
module uart_tx_periph #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        writeEnable,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        txd,
  output logic        irq_tx_empty
);
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    reg_sel;
  logic          push, pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bits;

  assign reg_sel      = addr[3:2];
  assign push         = writeEnable && (reg_sel == REG_TXDATA);
  assign txd          = txd_q;
  assign irq_tx_empty = fifo_empty && (state_q == TX_IDLE);
  assign unused_bits  = ^{addr[31:4], addr[1:0], writeData[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (writeData[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serial FSM; the divider is sampled only when a bit starts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_rdata;
          cnt_d     = bit_period_m1(baud_q);
          bit_idx_d = 3'd0;
          state_d   = TX_START;
        end else begin
          state_d   = TX_IDLE;
        end
      end
      TX_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = bit_period_m1(baud_q);
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
        end else begin
          cnt_d     = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = bit_period_m1(baud_q);
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt_q == 16'd0) state_d = TX_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level follows the registered state, so txd lags the FSM by one clock.
  always_comb begin
    case (state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Register writes; a dropped push wins over a clear in the same cycle.
  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (writeEnable && (reg_sel == REG_BAUDDIV)) baud_d = writeData[15:0];
    else                                         baud_d = baud_q;
    if (push && fifo_full) begin
      ovf_d = 1'b1;
    end else if (writeEnable && (reg_sel == REG_STATUS) && writeData[ST_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Read mux.
  always_comb begin
    status                   = 32'd0;
    status[ST_BUSY]          = (state_q != TX_IDLE);
    status[ST_FULL]          = fifo_full;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_OVF]           = ovf_q;
    status[ST_CNT_LSB +: 8]  = 8'(fifo_count);
    case (reg_sel)
      REG_STATUS:  readData = status;
      REG_BAUDDIV: readData = {16'd0, baud_q};
      default:     readData = 32'd0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= TX_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
      baud_q    <= BAUD_DIV_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
      baud_q    <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: scenario tasks plus a concurrent
// serial monitor that pops expected bytes from a scoreboard queue.
module tb_uart_tx_periph;

  localparam logic [31:0] A_TXDATA = 32'h0000_0000;
  localparam logic [31:0] A_STATUS = 32'h0000_0004;
  localparam logic [31:0] A_BAUD   = 32'h0000_0008;
  localparam logic [31:0] A_RSVD   = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        writeEnable = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        txd;
  logic        irq_tx_empty;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit   mon_en = 1'b0;
  int   mon_baud = 4;
  logic mon_prev, mon_s, mon_p;
  logic [7:0] mon_rx, mon_exp;

  uart_tx_periph #(.FIFO_DEPTH(8), .BAUD_DIV_RST(16'd434)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .writeEnable  (writeEnable),
    .addr         (addr),
    .writeData    (writeData),
    .readData     (readData),
    .txd          (txd),
    .irq_tx_empty (irq_tx_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Serial monitor: samples mid-bit, compares the byte against the scoreboard.
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rstn === 1'b1 && mon_prev === 1'b1 && txd === 1'b0) begin
        repeat (mon_baud / 2) @(negedge clk);
        mon_s = txd;
        for (int k = 0; k < 8; k++) begin
          repeat (mon_baud) @(negedge clk);
          mon_rx[k] = txd;
        end
        repeat (mon_baud) @(negedge clk);
        mon_p = txd;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: got unexpected byte %h, expected no frame", mon_rx);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({mon_p, mon_rx, mon_s} !== {1'b1, mon_exp, 1'b0}) begin
            errors++;
            $display("FAIL frame: got stop=%b data=%h start=%b, expected stop=1 data=%h start=0",
                     mon_p, mon_rx, mon_s, mon_exp);
          end
        end
      end
      mon_prev = txd;
    end
  end

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; writeData = d; writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = readData;
  endtask

  task automatic wait_fall(input int lim, output int waited);
    waited = 0;
    while (txd !== 1'b0 && waited < lim) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic run_len(input logic lvl, input int lim, output int len);
    len = 0;
    while (txd === lvl && len < lim) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (irq_tx_empty !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b expected 1", irq_tx_empty); end
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h expected 00000004", d); end
    read_reg(A_BAUD, d);
    checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_bauddiv: got %0d expected 434", d); end
    read_reg(A_TXDATA, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
    write_reg(A_RSVD, 32'hFFFF_FFFF);
    read_reg(A_RSVD, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL reserved_write: got status %h expected 00000004", d); end
  endtask

  task automatic test_single_byte;
    logic [9:0]  frame;
    logic [39:0] exp_w, obs_w;
    logic [31:0] d;
    int lat;
    write_reg(A_BAUD, 32'd4);
    mon_baud = 4; mon_en = 1'b1;
    exp_q.push_back(8'hA5);
    write_reg(A_TXDATA, 32'h0000_00A5);
    lat = 0;
    while (txd === 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL latency: got %0d clk expected 2", lat); end
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < 4; c++) exp_w[k*4 + c] = frame[k];
    for (int i = 0; i < 40; i++) begin
      obs_w[i] = txd;
      @(negedge clk);
    end
    checks++; if (obs_w !== exp_w) begin errors++; $display("FAIL waveform_a5: got %h expected %h", obs_w, exp_w); end
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL busy_falls: got status %h expected 00000004", d); end
    checks++; if (irq_tx_empty !== 1'b1) begin errors++; $display("FAIL irq_after_frame: got %b expected 1", irq_tx_empty); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_scoreboard: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int w, l1, h1, l2, hi;
    write_reg(A_BAUD, 32'd2);
    mon_baud = 2;
    @(negedge clk);
    addr = A_TXDATA; writeData = 32'h0000_0000; writeEnable = 1'b1; exp_q.push_back(8'h00);
    @(negedge clk);
    writeData = 32'h0000_00FF; exp_q.push_back(8'hFF);
    @(negedge clk);
    writeEnable = 1'b0;
    wait_fall(20, w);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start: got txd %b expected 0 within 20 clk", txd); end
    run_len(1'b0, 40, l1);
    run_len(1'b1, 40, h1);
    run_len(1'b0, 40, l2);
    checks++; if (l1 !== 18) begin errors++; $display("FAIL b2b_low1: got %0d expected 18", l1); end
    checks++; if (h1 !== 3) begin errors++; $display("FAIL b2b_gap: got %0d expected 3", h1); end
    checks++; if (l2 !== 2) begin errors++; $display("FAIL b2b_start2: got %0d expected 2", l2); end
    hi = 0;
    for (int i = 0; i < 18; i++) begin
      if (txd === 1'b1) hi++;
      @(negedge clk);
    end
    checks++; if (hi !== 18) begin errors++; $display("FAIL b2b_high2: got %0d expected 18", hi); end
    checks++; if (irq_tx_empty !== 1'b1) begin errors++; $display("FAIL b2b_total41: got irq %b expected 1 at clk 41", irq_tx_empty); end
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_scoreboard: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_baud_change;
    int w, len;
    logic lvl;
    mon_en = 1'b0;
    write_reg(A_BAUD, 32'd8);
    write_reg(A_TXDATA, 32'h0000_0055);
    wait_fall(20, w);
    run_len(1'b0, 20, len);
    checks++; if (len !== 8) begin errors++; $display("FAIL bc_start: got %0d expected 8", len); end
    run_len(1'b1, 20, len);
    run_len(1'b0, 20, len);
    // Bit 2 has just begun on the line: change the divider during it.
    addr = A_BAUD; writeData = 32'd3; writeEnable = 1'b1;
    len = 0;
    while (txd === 1'b1 && len < 20) begin
      len++;
      @(negedge clk);
      writeEnable = 1'b0;
    end
    checks++; if (len !== 8) begin errors++; $display("FAIL bc_bit2: got %0d expected 8", len); end
    for (int k = 3; k < 8; k++) begin
      lvl = (k % 2 == 0) ? 1'b1 : 1'b0;
      run_len(lvl, 20, len);
      checks++; if (len !== 3) begin errors++; $display("FAIL bc_bit%0d: got %0d expected 3", k, len); end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic [7:0]  b;
    int n;
    write_reg(A_BAUD, 32'd100);
    mon_baud = 100; mon_en = 1'b1;
    @(negedge clk);
    addr = A_TXDATA; writeEnable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b = 8'h30 + 8'(i);
      writeData = {24'd0, b};
      exp_q.push_back(b);
      @(negedge clk);
    end
    writeEnable = 1'b0;
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0083) begin errors++; $display("FAIL full_status: got %h expected 00000083", d); end
    checks++; if (irq_tx_empty !== 1'b0) begin errors++; $display("FAIL full_irq: got %b expected 0", irq_tx_empty); end
    write_reg(A_TXDATA, 32'h0000_00EE);
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_008B) begin errors++; $display("FAIL overflow_set: got %h expected 0000008B", d); end
    write_reg(A_STATUS, 32'hFFFF_FFF7);
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_008B) begin errors++; $display("FAIL overflow_keep: got %h expected 0000008B", d); end
    write_reg(A_STATUS, 32'h0000_0008);
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0083) begin errors++; $display("FAIL overflow_clear: got %h expected 00000083", d); end
    n = 0;
    while (exp_q.size() != 8 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++; if (exp_q.size() != 8) begin errors++; $display("FAIL first_frame: got %0d pending expected 8", exp_q.size()); end
    mon_en = 1'b0;
    apply_reset;
    exp_q.delete();
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL flush_reset: got %h expected 00000004", d); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    int w, lows;
    mon_en = 1'b0;
    write_reg(A_BAUD, 32'd4);
    @(negedge clk);
    addr = A_TXDATA; writeEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      writeData = 32'h0000_0000;
      @(negedge clk);
    end
    writeEnable = 1'b0;
    wait_fall(20, w);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL mid_start: got txd %b expected 0", txd); end
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd: got %b expected 1", txd); end
    read_reg(A_STATUS, d);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL mid_reset_status: got %h expected 00000004", d); end
    rstn = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL no_more_frames: got %0d low clk expected 0", lows); end
    checks++; if (irq_tx_empty !== 1'b1) begin errors++; $display("FAIL mid_irq: got %b expected 1", irq_tx_empty); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_baud_change();
    test_overflow();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
